// File: rtl/bridge_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bridge_ctrl_pkg
// Brief    : Shared types for the bridge buffer sequencer: FSM state encoding
//            and the read-alignment entry carried alongside buffer reads.
// Revision : 1.0 - initial release
// ============================================================================
package bridge_ctrl_pkg;

  // Widest slice index the alignment entry can carry (TOTAL_MODULES <= 256).
  localparam int unsigned C_SLICE_W_MAX = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WAIT_SA = 3'd2,
    READ    = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_e;

  typedef struct packed {
    logic                     valid;
    logic [C_SLICE_W_MAX-1:0] slice;
    logic                     last;
  } align_entry_t;

endpackage
`default_nettype wire

// File: rtl/bridge_rd_align.sv
`default_nettype none
// ============================================================================
// Module   : bridge_rd_align
// Brief    : RD_LATENCY-stage delay line that carries {valid, slice, last}
//            so the sideband lines up with the buffer's registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module bridge_rd_align
  import bridge_ctrl_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  align_entry_t entry_i,
  output align_entry_t entry_o
);

  align_entry_t stage_q [RD_LATENCY];

  // Shift one stage per cycle; reset empties the whole line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= entry_i;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign entry_o = stage_q[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/bridge_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bridge_buffer_ctrl
// Brief    : Bank-0 sequencer for one bridge buffer. Collects one tile of
//            TOTAL_DEPTH write beats, then streams it out address-major,
//            slice-minor with slice index / valid / last aligned to dout.
//            Optional macro BRIDGE_CTRL_STATUS_EN adds tile_count / drop_err.
// Revision : 1.0 - initial release
// ============================================================================
module bridge_buffer_ctrl
  import bridge_ctrl_pkg::*;
#(
  parameter int unsigned TOTAL_MODULES = 4,
  parameter int unsigned TOTAL_DEPTH   = 12,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned RD_LATENCY    = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             sa_ready,
  output logic                             bank0_ena,
  output logic                             bank0_wea,
  output logic [ADDR_WIDTH-1:0]            bank0_addra,
  output logic                             bank0_enb,
  output logic [ADDR_WIDTH-1:0]            bank0_addrb,
  output logic [$clog2(TOTAL_MODULES)-1:0] slicing_idx,
  output logic                             out_valid,
  output logic                             out_last,
  output logic                             busy,
`ifdef BRIDGE_CTRL_STATUS_EN
  output logic [15:0]                      tile_count,
  output logic                             drop_err,
`endif
  output logic                             done
);

  localparam int unsigned             C_SW       = $clog2(TOTAL_MODULES);
  localparam logic [ADDR_WIDTH-1:0]   C_ADDR_MAX = ADDR_WIDTH'(TOTAL_DEPTH - 1);
  localparam logic [C_SW-1:0]         C_SLC_MAX  = C_SW'(TOTAL_MODULES - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [C_SW-1:0]         slice_q, slice_d;
  align_entry_t            push_d;
  align_entry_t            align_out;
  logic                    unused_slice_bits;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      rd_addr_q <= '0;
      slice_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_addr_q <= rd_addr_d;
      slice_q   <= slice_d;
    end
  end

  // Next-state, counter advance and alignment push.
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_addr_d = rd_addr_q;
    slice_d   = slice_q;
    push_d    = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = WRITE;
      end
      WRITE: begin
        if (in_valid) begin
          if (wr_cnt_q == C_ADDR_MAX) begin
            wr_cnt_d = '0;
            state_d  = WAIT_SA;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      WAIT_SA: begin
        if (sa_ready) state_d = READ;
      end
      READ: begin
        push_d.valid = 1'b1;
        push_d.slice = C_SLICE_W_MAX'(slice_q);
        push_d.last  = (rd_addr_q == C_ADDR_MAX) && (slice_q == C_SLC_MAX);
        if (slice_q == C_SLC_MAX) begin
          slice_d = '0;
          if (rd_addr_q == C_ADDR_MAX) begin
            rd_addr_d = '0;
            state_d   = DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end else begin
          slice_d = slice_q + 1'b1;
        end
      end
      DRAIN: begin
        // The final entry is at the pipe output now; the pipe is empty next cycle.
        if (align_out.valid && align_out.last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  bridge_rd_align #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_align (
    .clk     (clk),
    .rst_n   (rst_n),
    .entry_i (push_d),
    .entry_o (align_out)
  );

  assign in_ready          = (state_q == WRITE);
  assign bank0_ena         = in_valid && (state_q == WRITE);
  assign bank0_wea         = bank0_ena;
  assign bank0_addra       = wr_cnt_q;
  assign bank0_enb         = (state_q == READ);
  assign bank0_addrb       = rd_addr_q;
  assign out_valid         = align_out.valid;
  assign out_last          = align_out.valid && align_out.last;
  assign slicing_idx       = align_out.slice[C_SW-1:0];
  assign unused_slice_bits = ^align_out.slice;
  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);

`ifdef BRIDGE_CTRL_STATUS_EN
  logic [15:0] tile_count_q;
  logic        drop_err_q;

  // Saturating tile counter and sticky protocol-violation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_count_q <= '0;
      drop_err_q   <= 1'b0;
    end else begin
      if ((state_q == DONE) && (tile_count_q != 16'hFFFF)) begin
        tile_count_q <= tile_count_q + 16'd1;
      end
      if ((in_valid && (state_q != WRITE)) || (start && (state_q != IDLE))) begin
        drop_err_q <= 1'b1;
      end
    end
  end

  assign tile_count = tile_count_q;
  assign drop_err   = drop_err_q;
`endif

endmodule
`default_nettype wire

// File: doc/bridge_buffer_ctrl.md
# bridge_buffer_ctrl

Sequencer that drives the bank-0 control signals of one bridge buffer (west or north) between the linear-projection stage and the systolic array. It accepts one tile of TOTAL_DEPTH write beats from the projection, then streams the tile out as TOTAL_DEPTH × TOTAL_MODULES slice beats to the systolic array. It emits `slicing_idx` and `out_valid` aligned to the buffer's read data. One instance serves each buffer; the west and north instances are independent.

## Interface
Parameters:
- TOTAL_MODULES, 4, slices per stored word; read beats per address
- TOTAL_DEPTH, 12, words per tile; write beats and read addresses per tile
- ADDR_WIDTH, 8, buffer address width; must satisfy TOTAL_DEPTH ≤ 2^ADDR_WIDTH
- RD_LATENCY, 2, cycles from `bank0_enb`/`bank0_addrb` to valid `bank0_dout`; ≥1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a tile; honoured only in IDLE
- in_valid  in  1  projection beat valid (data wired straight to bank0_din)
- in_ready  out  1  high only in WRITE
- sa_ready  in  1  systolic array can accept a full tile stream
- bank0_ena  out  1  port-A enable
- bank0_wea  out  1  port-A write enable
- bank0_addra  out  ADDR_WIDTH  write address
- bank0_enb  out  1  port-B enable
- bank0_addrb  out  ADDR_WIDTH  read address
- slicing_idx  out  $clog2(TOTAL_MODULES)  slice select, aligned to dout
- out_valid  out  1  bank0_dout slice valid this cycle
- out_last  out  1  final slice of tile, with out_valid
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at tile completion

## Operation
- States: IDLE → WRITE on `start`. WRITE → WAIT_SA after the TOTAL_DEPTH-th accepted beat. WAIT_SA → READ when `sa_ready`=1. READ → DRAIN after the last issue. DRAIN → DONE once the alignment pipe is empty. DONE → IDLE unconditionally.
- WRITE: `bank0_ena` = `bank0_wea` = `in_valid` & (state==WRITE), combinational. `bank0_addra` = write counter, 0..TOTAL_DEPTH-1, increments on each accepted beat. Gaps in `in_valid` stall without loss.
- READ: `bank0_enb`=1 every READ cycle, with no backpressure. `bank0_addrb` = read address, held for TOTAL_MODULES cycles. The slice counter runs 0..TOTAL_MODULES-1 and wraps, incrementing the address on wrap. Issue order is address-major, slice-minor, for TOTAL_DEPTH×TOTAL_MODULES issues in total.
- Each issue pushes {valid, slice, last} into a RD_LATENCY-deep delay line. Its output drives `out_valid`, `slicing_idx` and `out_last`.
- Counters compare against TOTAL_*-1 and wrap to 0; no address beyond TOTAL_DEPTH-1 is ever driven.
- `start` outside IDLE is ignored. `in_valid` outside WRITE produces no write. `sa_ready` is sampled only in WAIT_SA; dropping it during READ has no effect.
- Reset, including mid-tile, asynchronously clears the state to IDLE and clears all counters and the delay line. The tile is abandoned.

## Timing
- Reset values: every output 0, addresses 0, state IDLE.
- `start` at cycle 0 → WRITE and `in_ready`=1 at cycle 1.
- Last write beat at cycle k → WAIT_SA at k+1, `in_ready`=0.
- `sa_ready` high at cycle m in WAIT_SA → first `bank0_enb` at m+1.
- First `out_valid` at m+1+RD_LATENCY; then N=TOTAL_DEPTH×TOTAL_MODULES consecutive valid beats, with `out_last` on beat N.
- `done` is high one cycle after the final `out_valid`; `busy` falls the cycle after `done`.

## Configuration
- `BRIDGE_CTRL_STATUS_EN` defined: adds outputs `tile_count` (16 b, increments on `done`, saturates at 0xFFFF) and `drop_err` (sticky; set when `in_valid`=1 outside WRITE or `start`=1 outside IDLE; cleared only by reset).
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- `bridge_ctrl_pkg`: state enum (IDLE, WRITE, WAIT_SA, READ, DRAIN, DONE) and the alignment-entry struct {valid, slice, last}.
- Sub-module `bridge_rd_align`: parameterised RD_LATENCY-stage delay line for the struct, with asynchronous reset.

## Test plan
- Defaults, `start`, 12 back-to-back `in_valid` → `bank0_addra` 0..11, `wea` high 12 cycles, then `in_ready`=0.
- `in_valid` toggling 1,0,1,… during WRITE → still exactly 12 writes, addresses contiguous.
- `sa_ready` held low 5 cycles in WAIT_SA, then high → no `enb` before; 48 reads, `addrb` each held 4 cycles, first `out_valid` 3 cycles after `sa_ready`.
- Check alignment of the output stream → `slicing_idx` sequence 0,1,2,3 repeated 12 times; `out_last` only on beat 48; `done` the next cycle.
- `rst_n` asserted mid-READ → all outputs 0 immediately; a subsequent `start` runs a clean tile from address 0.
- With `BRIDGE_CTRL_STATUS_EN`: `in_valid` in IDLE sets `drop_err`; two full tiles give `tile_count`=2.
